nibble_packer: RTL

- Inverse of the nibble selector: accepts a stream of 4-bit nibbles and assembles them, LSB-first, into a 4*NIBBLES-bit word.
- Sits between a nibble producer and a 32-bit consumer.
- Valid/ready handshake on both the nibble side and the word side.
- FLUSH emits a partially filled word, zero-padded, together with a count of valid nibbles.

---
 rtl/nibble_packer.sv | 113 +++++++++++
 1 files changed

// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles LSB-first into a 4*NIBBLES-bit word with valid/ready on both sides.
// Optional word parity output enabled by defining NIBBLE_PARITY_EN.
module nibble_packer #(
   parameter int NIBBLES = 8,
   parameter int CNT_W   = 4
) (
   input  logic                   CLK,
   input  logic                   RESET_L,
   input  logic [3:0]             NIB_IN,
   input  logic                   NIB_VALID,
   output logic                   NIB_READY,
   input  logic                   FLUSH,
   output logic [4*NIBBLES-1:0]   WORD_OUT,
   output logic                   WORD_VALID,
   input  logic                   WORD_READY,
   output logic [CNT_W-1:0]       NIB_CNT
`ifdef NIBBLE_PARITY_EN
   ,
   output logic                   WORD_PAR
`endif
);

   localparam int W = 4 * NIBBLES;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]       asm_q, asm_d;
   logic [W-1:0]       word_q, word_d;
   logic [CNT_W-1:0]   ncnt_q, ncnt_d;
   logic [W-1:0]       asm_nxt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               xfer;
`ifdef NIBBLE_PARITY_EN
   logic               par_q, par_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      word_d  = word_q;
      ncnt_d  = ncnt_q;
      asm_nxt = asm_q;
      cnt_nxt = cnt_q;
      xfer    = 1'b0;
`ifdef NIBBLE_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         FILL: begin
            xfer = NIB_VALID;
            if (xfer) begin
               for (int unsigned i = 0; i < NIBBLES; i++) begin
                  if (CNT_W'(i) == cnt_q) asm_nxt[4*i +: 4] = NIB_IN;
               end
               cnt_nxt = cnt_q + CNT_W'(1);
            end
            // A same-cycle nibble is folded in before a flush emits the partial word.
            if ((xfer && (cnt_q == LAST)) || (FLUSH && (cnt_nxt != '0))) begin
               word_d  = asm_nxt;
               ncnt_d  = cnt_nxt;
               state_d = HOLD;
               cnt_d   = '0;
               asm_d   = '0;
`ifdef NIBBLE_PARITY_EN
               par_d   = ^asm_nxt;
`endif
            end else begin
               cnt_d = cnt_nxt;
               asm_d = asm_nxt;
            end
         end
         HOLD: begin
            if (WORD_READY) state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         state_q <= FILL;
         cnt_q   <= '0;
         asm_q   <= '0;
         word_q  <= '0;
         ncnt_q  <= '0;
`ifdef NIBBLE_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         word_q  <= word_d;
         ncnt_q  <= ncnt_d;
`ifdef NIBBLE_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign NIB_READY  = (state_q == FILL);
   assign WORD_VALID = (state_q == HOLD);
   assign WORD_OUT   = word_q;
   assign NIB_CNT    = ncnt_q;
`ifdef NIBBLE_PARITY_EN
   assign WORD_PAR   = par_q;
`endif

endmodule
